// File: rtl/mux_assert.sv
// Registered 3:1 priority multiplexer (sel3 > sel2 > sel1) with registered
// select-legality flags and embedded concurrent checks.
module mux_assert #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic [WIDTH-1:0] ip3,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel3,
  output logic [WIDTH-1:0] mux_op,
  output logic             sel_err,
  output logic             sel_none
);

  localparam int unsigned SEL_N = 3;
  localparam int unsigned CNT_W = 2;

  logic [SEL_N-1:0] sel_vec;
  logic [WIDTH-1:0] sel_val_c;
  logic [CNT_W-1:0] sel_cnt_c;

  assign sel_vec   = {sel3, sel2, sel1};
  assign sel_cnt_c = CNT_W'(sel1) + CNT_W'(sel2) + CNT_W'(sel3);

  // Priority resolution; overlapping selects are legal for data.
  always_comb begin
    sel_val_c = '0;
    if (sel3) begin
      sel_val_c = ip3;
    end else if (sel2) begin
      sel_val_c = ip2;
    end else if (sel1) begin
      sel_val_c = ip1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_op   <= '0;
      sel_err  <= 1'b0;
      sel_none <= 1'b0;
    end else begin
      mux_op   <= sel_val_c;
      sel_err  <= (sel_cnt_c >= CNT_W'(2));
      sel_none <= (sel_vec == '0);
    end
  end

`ifndef SYNTHESIS
  // Marks that the previous edge was a real capture, so $past never
  // reaches back across a reset pulse.
  logic past_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      past_ok <= 1'b0;
    end else begin
      past_ok <= 1'b1;
    end
  end

  a1_sel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(sel_vec))
    else $warning("mux_assert: more than one select high (%b)", sel_vec);

  a2_sel_known : assert property (@(posedge clk) disable iff (!rst_n)
    (|sel_vec) |-> !$isunknown(sel_val_c))
    else $error("mux_assert: selected input has X/Z");

  a3_out_match : assert property (@(posedge clk) disable iff (!rst_n)
    past_ok |-> (mux_op === $past(sel_val_c)))
    else $error("mux_assert: mux_op does not match previously selected value");

  a4_flags_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(sel_err && sel_none))
    else $error("mux_assert: sel_err and sel_none both high");

  a5_out_known : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({mux_op, sel_err, sel_none}))
    else $error("mux_assert: X/Z on outputs");
`endif

endmodule

// File: tb/tb_mux_assert.sv
// Directed plus random bench for mux_assert against a priority-list reference model.
module tb_mux_assert;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] ip1, ip2, ip3;
  logic             sel1, sel2, sel3;
  logic [WIDTH-1:0] mux_op;
  logic             sel_err, sel_none;

  int n_cmp = 0;
  int n_bad = 0;

  mux_assert #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ip1      (ip1),
    .ip2      (ip2),
    .ip3      (ip3),
    .sel1     (sel1),
    .sel2     (sel2),
    .sel3     (sel3),
    .mux_op   (mux_op),
    .sel_err  (sel_err),
    .sel_none (sel_none)
  );

  always #5 clk = ~clk;

  // Reference: walk inputs from highest priority down; first selected wins.
  function automatic logic [WIDTH-1:0] ref_data(input logic [WIDTH-1:0] a1,
                                                input logic [WIDTH-1:0] a2,
                                                input logic [WIDTH-1:0] a3,
                                                input logic [2:0] s);
    logic [WIDTH-1:0] ins [3];
    ins[0] = a1; ins[1] = a2; ins[2] = a3;
    for (int i = 2; i >= 0; i--) begin
      if (s[i]) return ins[i];
    end
    return '0;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a2,
                       input logic [WIDTH-1:0] a3, input logic [2:0] s);
    ip1 = a1; ip2 = a2; ip3 = a3;
    {sel3, sel2, sel1} = s;
  endtask

  // Apply inputs, clock once, then check all outputs against the model.
  task automatic step(input string tag, input logic [WIDTH-1:0] a1,
                      input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3,
                      input logic [2:0] s);
    logic [WIDTH-1:0] e_op;
    logic             e_err, e_none;
    drive(a1, a2, a3, s);
    e_op   = ref_data(a1, a2, a3, s);
    e_err  = ($countones(s) >= 2);
    e_none = (s == 3'b000);
    @(posedge clk);
    #1;
    check({tag, ".mux_op"}, mux_op, e_op);
    check({tag, ".sel_err"}, WIDTH'(sel_err), WIDTH'(e_err));
    check({tag, ".sel_none"}, WIDTH'(sel_none), WIDTH'(e_none));
  endtask

  initial begin
    logic [WIDTH-1:0] r1, r2, r3;
    logic [2:0]       rs;

    // Reset held with sel1 active: outputs stay zero, even across an edge.
    rst_n = 1'b0;
    drive(4'h2, 4'h4, 4'h8, 3'b001);
    #3;
    check("rst.mux_op", mux_op, 4'h0);
    check("rst.sel_err", WIDTH'(sel_err), 4'h0);
    check("rst.sel_none", WIDTH'(sel_none), 4'h0);
    @(posedge clk);
    #1;
    check("rst_edge.mux_op", mux_op, 4'h0);
    #2 rst_n = 1'b1;
    step("rst_release", 4'h2, 4'h4, 4'h8, 3'b001);

    // No select.
    step("none", 4'h2, 4'h4, 4'h8, 3'b000);

    // Sequential priority accumulation.
    step("seq1", 4'h2, 4'h4, 4'h8, 3'b001);
    step("seq12", 4'h2, 4'h4, 4'h8, 3'b011);
    step("seq123", 4'h2, 4'h4, 4'h8, 3'b111);

    // One-hot walk.
    step("walk3", 4'h2, 4'h4, 4'h8, 3'b100);
    step("walk2", 4'h2, 4'h4, 4'h8, 3'b010);
    step("walk1", 4'h2, 4'h4, 4'h8, 3'b001);

    // Mid-operation reset pulse between edges.
    step("pre_rst", 4'h2, 4'h4, 4'h8, 3'b100);
    rst_n = 1'b0;
    #1;
    check("midrst.mux_op", mux_op, 4'h0);
    check("midrst.sel_err", WIDTH'(sel_err), 4'h0);
    check("midrst.sel_none", WIDTH'(sel_none), 4'h0);
    #2 rst_n = 1'b1;
    step("post_rst", 4'h2, 4'h4, 4'h8, 3'b100);

    // Unknown on an unselected input must not disturb the result.
    step("x_unsel", 4'bxxxx, 4'h4, 4'h8, 3'b010);

    // Input wiggle between edges has no effect until the next edge.
    step("hold_a", 4'h1, 4'h5, 4'h9, 3'b010);
    drive(4'hf, 4'he, 4'hd, 3'b100);
    #2;
    check("between_edges.mux_op", mux_op, 4'h5);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r1 = WIDTH'($urandom);
      r2 = WIDTH'($urandom);
      r3 = WIDTH'($urandom);
      rs = 3'($urandom);
      step("rand", r1, r2, r3, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
